reorder_buffer_param: RTL
=========================

Name: reorder_buffer_param

Overview:
Parametrised reorder buffer, the successor of the fixed 16-entry ROB. It allocates ROB ids to the dispatcher in program order and accepts write-back from CDB_PORTS result buses in parallel. It forwards operand readiness and values to the dispatcher, with same-cycle CDB bypass. It commits at most one instruction per cycle in order, driving register-file, LSB, IF (misbranch flush) and predictor outputs.

Parameters:
ROB_DEPTH, 16, number of entries; power of two, at least 4.
ID_W, 5, ROB id width, log2(ROB_DEPTH)+1; id 0 means "none", valid ids are 1..ROB_DEPTH (entry index = id-1).
CDB_PORTS, 2, number of write-back buses (ALU, LSU, ...).
DATA_W, 32, value width.
ADDR_W, 32, PC width.
FULL_MARGIN, 3, full asserted when count >= ROB_DEPTH-FULL_MARGIN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; 0 freezes all state
alloc_valid  in  1  allocate entry at tail this cycle
alloc_is_jump / alloc_is_store / alloc_is_io  in  1 each  entry kind flags
alloc_rd  in  5  destination register (0 = none)
alloc_pred_taken  in  1  predictor decision
alloc_pc  in  ADDR_W  instruction PC
alloc_rob_id  out  ID_W  combinational: tail+1
full  out  1  combinational, per FULL_MARGIN
q1_id, q2_id  in  ID_W each  operand producer ids
q1_ready, q2_ready  out  1 each  producer result available
v1, v2  out  DATA_W each  producer value (0 if id 0)
cdb_valid  in  CDB_PORTS  per-port write-back strobe
cdb_rob_id  in  CDB_PORTS*ID_W  packed ids, port p at [p*ID_W +: ID_W]
cdb_value  in  CDB_PORTS*DATA_W  packed results
cdb_taken  in  CDB_PORTS  actual branch outcome
cdb_next_pc  in  CDB_PORTS*ADDR_W  correct next PC for jumps
io_rob_id  out  ID_W  head id if head busy and is_io, else 0
commit_valid  out  1  registered one-cycle commit pulse
commit_rd  out  5  rd of committed entry
commit_rob_id  out  ID_W  id of committed entry
commit_value  out  DATA_W  committed value
commit_store  out  1  committed entry is a store (LSB may write memory)
flush_valid  out  1  registered misbranch pulse
flush_pc  out  ADDR_W  redirect target
bp_update_valid  out  1  registered predictor-update pulse
bp_taken  out  1  actual outcome
bp_pc  out  ADDR_W  branch PC

Behaviour:
- Reset (async, rst=1): head=tail=count=0, all busy/ready bits 0. All registered outputs are 0 (commit_*, flush_*, bp_*).
- rdy=0: no state change; the registered pulses commit_valid, flush_valid and bp_update_valid are cleared at the next edge.
- Entry fields: busy, ready, is_jump, is_store, is_io, pred_taken, taken, rd, pc, next_pc, value.
- Allocate (alloc_valid and count < ROB_DEPTH): entry[tail] gets busy=1, ready=0 and the flags; tail wraps modulo ROB_DEPTH. When count == ROB_DEPTH the request is ignored. The dispatcher must honour full.
- CDB: for each port p with cdb_valid[p] and a busy target entry: ready=1, value, taken and next_pc are written. Writes to id 0 or non-busy entries are ignored. Two ports naming the same id: the highest p wins.
- Commit condition at head: busy && (ready || is_store). On commit:
  - commit_valid=1, with rd/id/value/commit_store registered; busy cleared; head advances.
  - If is_jump: bp_update_valid=1, bp_taken=taken, bp_pc=pc.
  - If taken != pred_taken: flush_valid=1, flush_pc=next_pc.
- Flush: the same edge that issues flush_valid clears all busy/ready bits and sets head=tail=count=0. Any same-cycle allocation and CDB writes are discarded. From the next cycle alloc_rob_id restarts at 1.
- count update: +1 on allocate, -1 on commit, unchanged when both occur in the same cycle.
- Operand lookup: qN_id==0 gives ready=0, v=0. If entry ready, return the stored value. Otherwise, if any cdb_valid port carries qN_id this cycle, ready=1 and v=that port's value (bypass, same priority as the write).
- Latency: CDB write to commit is at least 1 cycle; commit pulse to the next commit is 1 cycle.

Test Plan:
- Reset mid-operation: fill 5 entries, assert rst asynchronously -> outputs 0 immediately; alloc_rob_id=1, full=0, io_rob_id=0.
- In-order commit: alloc ids 1,2,3 (rd 5,6,7); CDB writes 3 then 1 then 2 with values 0x30,0x10,0x20 -> commits in order id1(rd5,0x10), id2, id3 on consecutive cycles.
- Wrap and full (depth 16, margin 3): alloc 13 -> full=1; 16 allocs leave a 17th ignored; commit 16 then alloc -> id wraps to 1.
- Dual-port CDB and bypass: ports 0 and 1 write ids 4 and 7 in the same cycle with q1_id=7 -> q1_ready=1, v1 equal to port-1 value that cycle; both entries ready next cycle.
- Mispredict: branch id 2 at pc 0x100, pred_taken=0, CDB taken=1, next_pc 0x140, ids 3-6 allocated -> commit of id 2 gives flush_valid=1, flush_pc=0x140, bp_update_valid=1, bp_taken=1; next cycle count=0 and alloc_rob_id=1.
- Store and IO: head is an io store with ready=0 -> io_rob_id=head id; commits without CDB with commit_store=1.

Source files
------------

// File: rtl/reorder_buffer_param.sv
// Parametrised reorder buffer: in-order allocation, multi-port CDB write-back
// with same-cycle operand bypass, and single in-order commit per cycle that
// drives register file, LSB, misbranch flush and predictor-update pulses.
module reorder_buffer_param #(
  parameter int ROB_DEPTH   = 16,
  parameter int ID_W        = 5,
  parameter int CDB_PORTS   = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int FULL_MARGIN = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      alloc_valid,
  input  logic                      alloc_is_jump,
  input  logic                      alloc_is_store,
  input  logic                      alloc_is_io,
  input  logic [4:0]                alloc_rd,
  input  logic                      alloc_pred_taken,
  input  logic [ADDR_W-1:0]         alloc_pc,
  output logic [ID_W-1:0]           alloc_rob_id,
  output logic                      full,
  input  logic [ID_W-1:0]           q1_id,
  input  logic [ID_W-1:0]           q2_id,
  output logic                      q1_ready,
  output logic                      q2_ready,
  output logic [DATA_W-1:0]         v1,
  output logic [DATA_W-1:0]         v2,
  input  logic [CDB_PORTS-1:0]      cdb_valid,
  input  logic [CDB_PORTS*ID_W-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_value,
  input  logic [CDB_PORTS-1:0]      cdb_taken,
  input  logic [CDB_PORTS*ADDR_W-1:0] cdb_next_pc,
  output logic [ID_W-1:0]           io_rob_id,
  output logic                      commit_valid,
  output logic [4:0]                commit_rd,
  output logic [ID_W-1:0]           commit_rob_id,
  output logic [DATA_W-1:0]         commit_value,
  output logic                      commit_store,
  output logic                      flush_valid,
  output logic [ADDR_W-1:0]         flush_pc,
  output logic                      bp_update_valid,
  output logic                      bp_taken,
  output logic [ADDR_W-1:0]         bp_pc
);

  localparam int IDX_W = $clog2(ROB_DEPTH);

  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [ID_W-1:0]      count;
  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] ready;

  logic                 is_jump    [ROB_DEPTH];
  logic                 is_store   [ROB_DEPTH];
  logic                 is_io      [ROB_DEPTH];
  logic                 pred_taken [ROB_DEPTH];
  logic                 taken      [ROB_DEPTH];
  logic [4:0]           rd         [ROB_DEPTH];
  logic [ADDR_W-1:0]    pc         [ROB_DEPTH];
  logic [ADDR_W-1:0]    next_pc    [ROB_DEPTH];
  logic [DATA_W-1:0]    value      [ROB_DEPTH];

  // Unpacked per-port views of the packed CDB buses
  logic [ID_W-1:0]      cdb_id  [CDB_PORTS];
  logic [IDX_W-1:0]     cdb_idx [CDB_PORTS];
  logic [DATA_W-1:0]    cdb_val [CDB_PORTS];
  logic [ADDR_W-1:0]    cdb_npc [CDB_PORTS];
  logic                 cdb_hit [CDB_PORTS];

  logic alloc_ok;
  logic commit_ok;
  logic mispredict;

  for (genvar gi = 0; gi < CDB_PORTS; gi++) begin : g_cdb
    assign cdb_id[gi]  = cdb_rob_id[gi*ID_W +: ID_W];
    assign cdb_idx[gi] = IDX_W'(cdb_id[gi] - ID_W'(1));
    assign cdb_val[gi] = cdb_value[gi*DATA_W +: DATA_W];
    assign cdb_npc[gi] = cdb_next_pc[gi*ADDR_W +: ADDR_W];
    // Only live entries accept results; id 0 is the "none" id
    assign cdb_hit[gi] = cdb_valid[gi] && (cdb_id[gi] != '0) && busy[cdb_idx[gi]];
  end

  assign alloc_ok     = alloc_valid && (count != ID_W'(ROB_DEPTH));
  // Stores retire without a CDB result; the LSB performs the write afterwards
  assign commit_ok    = busy[head] && (ready[head] || is_store[head]);
  assign mispredict   = commit_ok && (taken[head] != pred_taken[head]);
  assign alloc_rob_id = ID_W'(tail) + ID_W'(1);
  assign full         = (count >= ID_W'(ROB_DEPTH - FULL_MARGIN));
  assign io_rob_id    = (busy[head] && is_io[head]) ? ID_W'(head) + ID_W'(1) : '0;

  // Returns {ready, value} for a producer id, stored value first, then CDB bypass
  function automatic logic [DATA_W:0] lookup(input logic [ID_W-1:0] qid);
    logic [IDX_W-1:0] idx;
    logic [DATA_W:0]  res;
    idx = IDX_W'(qid - ID_W'(1));
    res = '0;
    if (qid != '0) begin
      if (ready[idx]) begin
        res = {1'b1, value[idx]};
      end else begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (cdb_valid[p] && (cdb_id[p] == qid)) res = {1'b1, cdb_val[p]};
        end
      end
    end
    return res;
  endfunction

  // Operand readiness/value forwarding for both dispatcher operands
  always_comb begin
    {q1_ready, v1} = lookup(q1_id);
    {q2_ready, v2} = lookup(q2_id);
  end

  // Pointers, status bits and registered commit/flush/predictor pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      commit_valid    <= 1'b0;
      commit_rd       <= '0;
      commit_rob_id   <= '0;
      commit_value    <= '0;
      commit_store    <= 1'b0;
      flush_valid     <= 1'b0;
      flush_pc        <= '0;
      bp_update_valid <= 1'b0;
      bp_taken        <= 1'b0;
      bp_pc           <= '0;
    end else if (!rdy) begin
      commit_valid    <= 1'b0;
      flush_valid     <= 1'b0;
      bp_update_valid <= 1'b0;
    end else begin
      commit_valid    <= commit_ok;
      bp_update_valid <= commit_ok && is_jump[head];
      flush_valid     <= mispredict;
      if (commit_ok) begin
        commit_rd     <= rd[head];
        commit_rob_id <= ID_W'(head) + ID_W'(1);
        commit_value  <= value[head];
        commit_store  <= is_store[head];
        if (is_jump[head]) begin
          bp_taken <= taken[head];
          bp_pc    <= pc[head];
        end
        if (mispredict) flush_pc <= next_pc[head];
      end
      if (mispredict) begin
        // Everything younger than the branch is wrong-path: drop it all,
        // including this cycle's allocation and write-backs
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (alloc_ok) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (cdb_hit[p]) ready[cdb_idx[p]] <= 1'b1;
        end
        if (commit_ok) begin
          busy[head] <= 1'b0;
          head       <= head + IDX_W'(1);
        end
        if (alloc_ok && !commit_ok)      count <= count + ID_W'(1);
        else if (!alloc_ok && commit_ok) count <= count - ID_W'(1);
      end
    end
  end

  // Entry payload: written at allocation and by CDB results (later port wins)
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (alloc_ok) begin
        is_jump[tail]    <= alloc_is_jump;
        is_store[tail]   <= alloc_is_store;
        is_io[tail]      <= alloc_is_io;
        pred_taken[tail] <= alloc_pred_taken;
        taken[tail]      <= 1'b0;
        rd[tail]         <= alloc_rd;
        pc[tail]         <= alloc_pc;
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_hit[p]) begin
          value[cdb_idx[p]]   <= cdb_val[p];
          taken[cdb_idx[p]]   <= cdb_taken[p];
          next_pc[cdb_idx[p]] <= cdb_npc[p];
        end
      end
    end
  end

endmodule
